// File: rtl/pi1_router.sv
// Routes one PerInt master to SLAVECOUNT slaves through an address map summed from slave sizes at reset.
// Zero added latency; m_rdy_o stalls until both the previous and the newly addressed slave are ready.
module pi1_router #(
    parameter int SLAVECOUNT        = 2,
    parameter int ARCHBITSZ         = 16,
    parameter int DEFAULTSLAVEINDEX = 0,
    localparam int ADDRBITSZ        = ARCHBITSZ - $clog2(ARCHBITSZ/8),
    localparam int SELW             = ARCHBITSZ/8,
    localparam int IDXW             = (SLAVECOUNT > 1) ? $clog2(SLAVECOUNT) : 1
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [1:0]                      m_op_i,
    input  logic [ADDRBITSZ-1:0]            m_addr_i,
    input  logic [ARCHBITSZ-1:0]            m_data_i,
    input  logic [SELW-1:0]                 m_sel_i,
    output logic [ARCHBITSZ-1:0]            m_data_o,
    output logic                            m_rdy_o,
    output logic [ADDRBITSZ-1:0]            m_mapsz_o,
    output logic [2*SLAVECOUNT-1:0]         s_op_o_flat,
    output logic [ADDRBITSZ*SLAVECOUNT-1:0] s_addr_o_flat,
    output logic [ARCHBITSZ*SLAVECOUNT-1:0] s_data_o_flat,
    output logic [SELW*SLAVECOUNT-1:0]      s_sel_o_flat,
    input  logic [ARCHBITSZ*SLAVECOUNT-1:0] s_data_i_flat,
    input  logic [SLAVECOUNT-1:0]           s_rdy_i_flat,
    input  logic [ADDRBITSZ*SLAVECOUNT-1:0] s_mapsz_i_flat
);

    localparam logic [1:0] PINOOP = 2'b00;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t               state;
    logic [IDXW-1:0]      idx;
    logic [IDXW-1:0]      prevsel;
    logic [IDXW-1:0]      cursel;
    logic                 mapped;
    logic                 run;
    logic [ADDRBITSZ:0]   acc;
    logic [ADDRBITSZ:0]   base_q [SLAVECOUNT];
    logic [ADDRBITSZ-1:0] size_q [SLAVECOUNT];
    logic [ADDRBITSZ-1:0] mapsz_in [SLAVECOUNT];
    logic [ARCHBITSZ-1:0] sdata_in [SLAVECOUNT];

    always_comb begin
        for (int i = 0; i < SLAVECOUNT; i++) begin
            mapsz_in[i] = s_mapsz_i_flat[i*ADDRBITSZ +: ADDRBITSZ];
            sdata_in[i] = s_data_i_flat[i*ARCHBITSZ +: ARCHBITSZ];
        end
    end

    // Walk downwards so the lowest matching index wins on overlap.
    always_comb begin
        cursel = IDXW'(DEFAULTSLAVEINDEX);
        mapped = 1'b0;
        for (int i = SLAVECOUNT-1; i >= 0; i--) begin
            if (size_q[i] != '0 &&
                {1'b0, m_addr_i} >= base_q[i] &&
                {1'b0, m_addr_i} <  base_q[i] + {1'b0, size_q[i]}) begin
                cursel = IDXW'(i);
                mapped = 1'b1;
            end
        end
    end

    assign run       = (state == ST_RUN);
    assign m_rdy_o   = run && s_rdy_i_flat[prevsel] && s_rdy_i_flat[cursel];
    assign m_data_o  = sdata_in[prevsel];
    assign m_mapsz_o = run ? acc[ADDRBITSZ-1:0] : '0;

    always_comb begin
        s_op_o_flat   = '0;
        s_addr_o_flat = '0;
        s_data_o_flat = '0;
        s_sel_o_flat  = '0;
        for (int i = 0; i < SLAVECOUNT; i++) begin
            if (m_rdy_o && cursel == IDXW'(i))
                s_op_o_flat[2*i +: 2] = m_op_i;
            if (mapped && cursel == IDXW'(i))
                s_addr_o_flat[i*ADDRBITSZ +: ADDRBITSZ] = m_addr_i - base_q[i][ADDRBITSZ-1:0];
            else
                s_addr_o_flat[i*ADDRBITSZ +: ADDRBITSZ] = m_addr_i;
            s_data_o_flat[i*ARCHBITSZ +: ARCHBITSZ] = m_data_i;
            s_sel_o_flat[i*SELW +: SELW]            = m_sel_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_INIT;
            idx     <= '0;
            acc     <= '0;
            prevsel <= IDXW'(DEFAULTSLAVEINDEX);
        end else begin
            case (state)
                ST_INIT: begin
                    base_q[idx] <= acc;
                    size_q[idx] <= mapsz_in[idx];
                    acc         <= acc + {1'b0, mapsz_in[idx]};
                    idx         <= idx + IDXW'(1);
                    if (idx == IDXW'(SLAVECOUNT-1))
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (m_rdy_o && m_op_i != PINOOP)
                        prevsel <= cursel;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_pi1_router.sv
// Directed bench for pi1_router with three slaves: map build, routing table, stalls, switches, reset.
module tb_pi1_router;

    localparam int SC = 3;
    localparam int AB = 15;

    logic            clk;
    logic            rst;
    logic [1:0]      m_op;
    logic [AB-1:0]   m_addr;
    logic [15:0]     m_wdata;
    logic [1:0]      m_sel;
    logic [15:0]     m_rdata;
    logic            m_rdy;
    logic [AB-1:0]   m_mapsz;
    logic [2*SC-1:0] s_op_flat;
    logic [AB*SC-1:0] s_addr_flat;
    logic [16*SC-1:0] s_wdata_flat;
    logic [2*SC-1:0] s_sel_flat;
    logic [15:0]     sd [SC];
    logic [SC-1:0]   srdy;
    logic [AB-1:0]   msz [SC];

    int n_chk  = 0;
    int n_fail = 0;
    int deliv;

    pi1_router #(.SLAVECOUNT(SC), .ARCHBITSZ(16), .DEFAULTSLAVEINDEX(0)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .m_op_i         (m_op),
        .m_addr_i       (m_addr),
        .m_data_i       (m_wdata),
        .m_sel_i        (m_sel),
        .m_data_o       (m_rdata),
        .m_rdy_o        (m_rdy),
        .m_mapsz_o      (m_mapsz),
        .s_op_o_flat    (s_op_flat),
        .s_addr_o_flat  (s_addr_flat),
        .s_data_o_flat  (s_wdata_flat),
        .s_sel_o_flat   (s_sel_flat),
        .s_data_i_flat  ({sd[2], sd[1], sd[0]}),
        .s_rdy_i_flat   (srdy),
        .s_mapsz_i_flat ({msz[2], msz[1], msz[0]})
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    op;
        logic [AB-1:0] addr;
        logic [15:0]   wdata;
        logic [1:0]    sel;
        logic [SC-1:0] rdy;
        logic          exp_rdy;
        logic [2*SC-1:0] exp_sop;
        int            tgt;
        logic [AB-1:0] exp_saddr;
        logic [15:0]   exp_data;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [1:0] sop(input int i);
        return s_op_flat[2*i +: 2];
    endfunction

    function automatic logic [AB-1:0] saddr(input int i);
        return s_addr_flat[AB*i +: AB];
    endfunction

    initial begin
        // op, addr, wdata, sel, rdy, exp_rdy, exp_sop, tgt, exp_saddr, exp_data
        vt[0]  = '{2'b00, 15'd0,  16'h0000, 2'b00, 3'b111, 1'b1, 6'b000000, 0, 15'd0,  16'h1110};
        vt[1]  = '{2'b01, 15'd20, 16'h1234, 2'b11, 3'b111, 1'b1, 6'b000100, 1, 15'd4,  16'h1110};
        vt[2]  = '{2'b10, 15'd0,  16'h0000, 2'b11, 3'b111, 1'b1, 6'b000010, 0, 15'd0,  16'h2220};
        vt[3]  = '{2'b10, 15'd15, 16'h0000, 2'b11, 3'b111, 1'b1, 6'b000010, 0, 15'd15, 16'h1110};
        vt[4]  = '{2'b10, 15'd47, 16'h0000, 2'b11, 3'b111, 1'b1, 6'b001000, 1, 15'd31, 16'h1110};
        vt[5]  = '{2'b10, 15'd48, 16'h0000, 2'b11, 3'b111, 1'b1, 6'b100000, 2, 15'd0,  16'h2220};
        vt[6]  = '{2'b11, 15'd55, 16'h0000, 2'b11, 3'b111, 1'b1, 6'b110000, 2, 15'd7,  16'h3330};
        vt[7]  = '{2'b10, 15'd56, 16'h0000, 2'b11, 3'b111, 1'b1, 6'b000010, 0, 15'd56, 16'h3330};
        vt[8]  = '{2'b10, 15'd60, 16'h0000, 2'b11, 3'b111, 1'b1, 6'b000010, 0, 15'd60, 16'h1110};
        vt[9]  = '{2'b01, 15'd20, 16'h0BAD, 2'b01, 3'b101, 1'b0, 6'b000000, 1, 15'd4,  16'h1110};
        vt[10] = '{2'b00, 15'd20, 16'h0000, 2'b00, 3'b101, 1'b0, 6'b000000, 1, 15'd4,  16'h1110};
        vt[11] = '{2'b00, 15'd0,  16'h0000, 2'b00, 3'b110, 1'b0, 6'b000000, 0, 15'd0,  16'h1110};

        rst = 1'b1; m_op = 2'b00; m_addr = '0; m_wdata = '0; m_sel = '0;
        srdy = 3'b111;
        sd[0] = 16'h1110; sd[1] = 16'h2220; sd[2] = 16'h3330;
        msz[0] = 15'd16; msz[1] = 15'd32; msz[2] = 15'd8;
        repeat (2) tick();

        // Map build: three INIT edges with a write held on the master
        rst = 1'b0; m_op = 2'b01; m_addr = 15'd20;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("init_rdy",   32'(m_rdy), 32'd0);
            chk("init_sop",   32'(s_op_flat), 32'd0);
            chk("init_mapsz", 32'(m_mapsz), 32'd0);
            tick();
        end
        m_op = 2'b00;
        #2;
        chk("run_rdy",   32'(m_rdy), 32'd1);
        chk("run_mapsz", 32'(m_mapsz), 32'd56);

        for (int v = 0; v < 12; v++) begin
            m_op = vt[v].op; m_addr = vt[v].addr; m_wdata = vt[v].wdata;
            m_sel = vt[v].sel; srdy = vt[v].rdy;
            #2;
            chk($sformatf("vec%0d_rdy", v),   32'(m_rdy), 32'(vt[v].exp_rdy));
            chk($sformatf("vec%0d_sop", v),   32'(s_op_flat), 32'(vt[v].exp_sop));
            chk($sformatf("vec%0d_saddr", v), 32'(saddr(vt[v].tgt)), 32'(vt[v].exp_saddr));
            chk($sformatf("vec%0d_rdata", v), 32'(m_rdata), 32'(vt[v].exp_data));
            if (vt[v].op == 2'b01 && vt[v].exp_rdy) begin
                for (int s = 0; s < SC; s++) begin
                    chk($sformatf("vec%0d_wdata%0d", v, s), 32'(s_wdata_flat[16*s +: 16]), 32'(vt[v].wdata));
                    chk($sformatf("vec%0d_sel%0d", v, s),   32'(s_sel_flat[2*s +: 2]), 32'(vt[v].sel));
                end
            end
            tick();
        end

        // Slow read from slave2
        srdy = 3'b111; m_op = 2'b10; m_addr = 15'd50;
        #2;
        chk("slow_rdy0",  32'(m_rdy), 32'd1);
        chk("slow_sop",   32'(s_op_flat), 32'(6'b100000));
        chk("slow_saddr", 32'(saddr(2)), 32'd2);
        tick();
        m_op = 2'b00; srdy = 3'b011;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("slow_stall", 32'(m_rdy), 32'd0);
            tick();
        end
        srdy = 3'b111; sd[2] = 16'hBEEF;
        #2;
        chk("slow_rdy1",  32'(m_rdy), 32'd1);
        chk("slow_rdata", 32'(m_rdata), 32'hBEEF);
        tick();
        sd[2] = 16'h3330;

        // Switch from slave0 to slave1 while slave0 is still busy
        m_op = 2'b10; m_addr = 15'd0;
        #2;
        chk("sw_rd_sop", 32'(s_op_flat), 32'(6'b000010));
        tick();
        m_op = 2'b01; m_addr = 15'd20; m_wdata = 16'h55AA; srdy = 3'b110;
        deliv = 0;
        for (int k = 0; k < 2; k++) begin
            #2;
            chk("sw_stall_rdy", 32'(m_rdy), 32'd0);
            chk("sw_stall_op1", 32'(sop(1)), 32'd0);
            if (sop(1) != 2'b00) deliv++;
            tick();
        end
        srdy = 3'b111;
        #2;
        chk("sw_go_rdy", 32'(m_rdy), 32'd1);
        chk("sw_go_op1", 32'(sop(1)), 32'd1);
        if (sop(1) != 2'b00) deliv++;
        tick();
        m_op = 2'b00;
        #2;
        if (sop(1) != 2'b00) deliv++;
        chk("sw_once", 32'(deliv), 32'd1);

        // Zero-size slave0: sizes 0,8,0
        rst = 1'b1; msz[0] = 15'd0; msz[1] = 15'd8; msz[2] = 15'd0;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        #2;
        chk("zs_mapsz", 32'(m_mapsz), 32'd8);
        m_op = 2'b10; m_addr = 15'd3;
        #2;
        chk("zs_sop",   32'(s_op_flat), 32'(6'b001000));
        chk("zs_saddr", 32'(saddr(1)), 32'd3);
        tick();

        // Reset while slave1 stalls a read, then rebuild with sizes 4,4,0
        srdy = 3'b101;
        #2;
        chk("rst_pre_stall", 32'(m_rdy), 32'd0);
        rst = 1'b1; msz[0] = 15'd4; msz[1] = 15'd4; msz[2] = 15'd0;
        tick();
        chk("rst_sop", 32'(s_op_flat), 32'd0);
        chk("rst_rdy", 32'(m_rdy), 32'd0);
        rst = 1'b0; m_addr = 15'd0;
        repeat (3) tick();
        #2;
        chk("reinit_mapsz", 32'(m_mapsz), 32'd8);
        chk("reinit_prevsel_rdy", 32'(m_rdy), 32'd1);
        chk("reinit_sop0", 32'(s_op_flat), 32'(6'b000010));
        tick();
        srdy = 3'b111; m_addr = 15'd5;
        #2;
        chk("reinit_sop1",   32'(s_op_flat), 32'(6'b001000));
        chk("reinit_saddr1", 32'(saddr(1)), 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
